lcd_text_scheduler: RTL and testbench

- Sits between the Bluetooth UART receiver and the character-LCD bus engine of a 16x2 HD44780-style display.
- Buffers received bytes in a small FIFO. Runs the power-up init command sequence, then turns each byte into LCD commands and data writes.
- Tracks the cursor, wraps across both lines, and interprets control characters (form feed, carriage return, backspace).
- The downstream engine owns all enable-pulse and settle timing. This block only decides what is sent and in which order.

---
 rtl/lcd_text_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_lcd_text_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_scheduler.sv
// lcd_text_scheduler: buffers UART bytes, runs the HD44780 power-up command
// sequence, then turns each byte into address/data writes for the LCD engine
// while tracking a 2-line cursor.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   rx_data, rx_valid    byte strobe from the UART receiver
//   cmd_valid/ready      valid/ready handshake towards the LCD bus engine
//   cmd_rs, cmd_data     0 = instruction, 1 = character; byte to send
//   init_done            init command sequence finished
//   overflow             sticky, a byte was dropped on a full FIFO
//   fifo_count           bytes currently buffered
//   cursor_row/col       current cursor position
module lcd_text_scheduler #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [19:0] INIT_WAIT  = 20'd750_000,
    parameter int unsigned COLS       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_rs,
    output logic [7:0]                    cmd_data,
    output logic                          init_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          cursor_row,
    output logic [3:0]                    cursor_col
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] Full    = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  LastCol = 4'(COLS - 1);

    typedef enum logic [2:0] {
        StInitWait, StInitCmd, StIdle, StSetAddr, StWriteChar, StClear
    } state_e;

    state_e          state_q, state_d;
    logic [19:0]     wait_q, wait_d;
    logic [1:0]      init_idx_q, init_idx_d;
    logic            valid_q, valid_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            init_done_q, init_done_d;
    logic            ovf_q, ovf_d;
    logic            row_q, row_d;
    logic [3:0]      col_q, col_d;
    // Cursor position to commit on the final transfer of a sequence.
    logic            nrow_q, nrow_d;
    logic [3:0]      ncol_q, ncol_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      char_q, char_d;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [7:0]      head;
    logic            empty, full, pop, push, xfer;
    logic            adv_row, dec_row;
    logic [3:0]      adv_col, dec_col;
    logic [7:0]      init_byte;

    assign head  = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == Full);
    assign pop   = (state_q == StIdle) && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push  = rx_valid && (!full || pop);
    assign xfer  = valid_q && cmd_ready;

    assign adv_col = (col_q == LastCol) ? 4'd0 : col_q + 4'd1;
    assign adv_row = (col_q == LastCol) ? ~row_q : row_q;
    assign dec_col = (col_q == 4'd0) ? LastCol : col_q - 4'd1;
    assign dec_row = (col_q == 4'd0) ? 1'b0 : row_q;

    always_comb begin
        unique case (init_idx_q)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        init_idx_d  = init_idx_q;
        valid_d     = valid_q;
        rs_d        = rs_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        ovf_d       = ovf_q | (rx_valid && full && !pop);
        row_d       = row_q;
        col_d       = col_q;
        nrow_d      = nrow_q;
        ncol_d      = ncol_q;
        addr_d      = addr_q;
        char_d      = char_q;

        unique case (state_q)
            StInitWait: begin
                if (wait_q == INIT_WAIT - 20'd1) state_d = StInitCmd;
                else                             wait_d  = wait_q + 20'd1;
            end
            StInitCmd: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    rs_d    = 1'b0;
                    data_d  = init_byte;
                end else if (cmd_ready) begin
                    valid_d = 1'b0;
                    if (init_idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                    end
                end
            end
            StIdle: begin
                if (!empty) begin
                    if (head >= 8'h20 && head <= 8'h7E) begin
                        addr_d  = {1'b1, row_q, 2'b00, col_q};
                        char_d  = head;
                        nrow_d  = adv_row;
                        ncol_d  = adv_col;
                        state_d = StSetAddr;
                    end else if (head == 8'h0C) begin
                        nrow_d  = 1'b0;
                        ncol_d  = 4'd0;
                        state_d = StClear;
                    end else if (head == 8'h0D) begin
                        col_d = 4'd0;
                        row_d = ~row_q;
                    end else if (head == 8'h08 && (row_q || col_q != 4'd0)) begin
                        // Blank the previous cell and leave the cursor on it.
                        addr_d  = {1'b1, dec_row, 2'b00, dec_col};
                        char_d  = 8'h20;
                        nrow_d  = dec_row;
                        ncol_d  = dec_col;
                        state_d = StSetAddr;
                    end
                end
            end
            StSetAddr: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    rs_d    = 1'b0;
                    data_d  = addr_q;
                end else if (cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = StWriteChar;
                end
            end
            StWriteChar, StClear: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    rs_d    = (state_q == StWriteChar);
                    data_d  = (state_q == StWriteChar) ? char_q : 8'h01;
                end else if (cmd_ready) begin
                    valid_d = 1'b0;
                    row_d   = nrow_q;
                    col_d   = ncol_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StInitWait;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInitWait;
            wait_q      <= '0;
            init_idx_q  <= '0;
            valid_q     <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            init_done_q <= 1'b0;
            ovf_q       <= 1'b0;
            row_q       <= 1'b0;
            col_q       <= 4'd0;
            nrow_q      <= 1'b0;
            ncol_q      <= 4'd0;
            addr_q      <= 8'h00;
            char_q      <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            init_idx_q  <= init_idx_d;
            valid_q     <= valid_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
            ovf_q       <= ovf_d;
            row_q       <= row_d;
            col_q       <= col_d;
            nrow_q      <= nrow_d;
            ncol_q      <= ncol_d;
            addr_q      <= addr_d;
            char_q      <= char_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= rx_data;
    end

    assign cmd_valid  = valid_q;
    assign cmd_rs     = rs_q;
    assign cmd_data   = data_q;
    assign init_done  = init_done_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule

// File: tb/tb_lcd_text_scheduler.sv
// Directed bench for lcd_text_scheduler: init sequence, character placement
// and wrap, control characters, FIFO overflow under stall, reset mid-transfer.
module tb_lcd_text_scheduler;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [19:0] INIT_WAIT  = 20'd20;
    localparam int unsigned COLS       = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       init_done;
    logic       overflow;
    logic [2:0] fifo_count;
    logic       cursor_row;
    logic [3:0] cursor_col;

    int total = 0;
    int bad   = 0;

    logic [8:0] xfer_q [$];
    logic       hold_vld = 1'b0;
    logic [8:0] hold_val = '0;

    lcd_text_scheduler #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .INIT_WAIT  (INIT_WAIT),
        .COLS       (COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rs     (cmd_rs),
        .cmd_data   (cmd_data),
        .init_done  (init_done),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge; the negedge sees what the
    // next posedge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_vld) check_eq("stall_hold", {cmd_valid, cmd_rs, cmd_data}, {1'b1, hold_val});
            if (cmd_valid && cmd_ready) xfer_q.push_back({cmd_rs, cmd_data});
            hold_vld = cmd_valid && !cmd_ready;
            hold_val = {cmd_rs, cmd_data};
        end else begin
            hold_vld = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_xfers(input int n);
        int cnt = 0;
        while (xfer_q.size() < n && cnt < 300) begin
            tick();
            cnt++;
        end
        check_eq("xfer_timeout", 32'(xfer_q.size() >= n), 32'd1);
    endtask

    task automatic expect_xfer(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = (xfer_q.size() != 0) ? xfer_q.pop_front() : 9'h1FF;
        check_eq(tag, 32'(got), 32'(exp));
    endtask

    task automatic expect_cursor(input string tag, input logic row, input logic [3:0] col);
        check_eq(tag, {cursor_row, cursor_col}, {row, col});
    endtask

    initial begin
        logic       any_valid;
        logic       found;
        logic [7:0] ch;
        int         p;

        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cmd_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", cmd_valid, 0);
        check_eq("rst_rs", cmd_rs, 0);
        check_eq("rst_data", cmd_data, 8'h00);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_fifo_count", fifo_count, 0);
        expect_cursor("rst_cursor", 1'b0, 4'd0);
        rst = 1'b0;

        any_valid = 1'b0;
        for (int i = 0; i < int'(INIT_WAIT); i++) begin
            tick();
            any_valid |= cmd_valid;
        end
        check_eq("init_quiet", any_valid, 0);

        wait_xfers(3);
        check_eq("init_done_early", init_done, 0);
        wait_xfers(4);
        check_eq("init_done", init_done, 1);
        expect_xfer("init0", 9'h038);
        expect_xfer("init1", 9'h00C);
        expect_xfer("init2", 9'h006);
        expect_xfer("init3", 9'h001);

        send_byte(8'h41);
        wait_xfers(2);
        expect_xfer("a_addr", 9'h080);
        expect_xfer("a_char", 9'h141);
        expect_cursor("a_cursor", 1'b0, 4'd1);

        send_byte(8'h0D);
        send_byte(8'h42);
        wait_xfers(2);
        expect_xfer("b_addr", 9'h0C0);
        expect_xfer("b_char", 9'h142);
        expect_cursor("b_cursor", 1'b1, 4'd1);

        send_byte(8'h0C);
        wait_xfers(1);
        expect_xfer("ff_clear", 9'h001);
        expect_cursor("ff_cursor", 1'b0, 4'd0);

        // 49 characters from 0,0: line wrap at 16, screen wrap at 32.
        for (int i = 0; i < 49; i++) begin
            ch = 8'h41 + 8'(i % 26);
            p  = i % 32;
            send_byte(ch);
            wait_xfers(2);
            expect_xfer("wrap_addr", {1'b0, 1'b1, (p >= 16) ? 1'b1 : 1'b0, 2'b00, 4'(p % 16)});
            expect_xfer("wrap_char", {1'b1, ch});
        end
        expect_cursor("wrap_cursor", 1'b1, 4'd1);

        send_byte(8'h08);
        wait_xfers(2);
        expect_xfer("bs1_addr", 9'h0C0);
        expect_xfer("bs1_char", 9'h120);
        expect_cursor("bs1_cursor", 1'b1, 4'd0);

        send_byte(8'h08);
        wait_xfers(2);
        expect_xfer("bs2_addr", 9'h08F);
        expect_xfer("bs2_char", 9'h120);
        expect_cursor("bs2_cursor", 1'b0, 4'd15);

        send_byte(8'h0C);
        wait_xfers(1);
        expect_xfer("ff2_clear", 9'h001);
        expect_cursor("ff2_cursor", 1'b0, 4'd0);

        // Backspace at home and non-printables produce nothing.
        send_byte(8'h08);
        send_byte(8'h07);
        send_byte(8'h7F);
        send_byte(8'hFF);
        for (int i = 0; i < 20; i++) tick();
        check_eq("silent_xfers", xfer_q.size(), 0);
        expect_cursor("silent_cursor", 1'b0, 4'd0);
        check_eq("silent_fifo", fifo_count, 0);

        // Reset while a character sequence is in flight.
        send_byte(8'h78);
        send_byte(8'h79);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (cmd_valid && cmd_rs) found = 1'b1;
            else tick();
        end
        check_eq("midchar_seen", found, 1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_valid", cmd_valid, 0);
        check_eq("mid_rst_fifo", fifo_count, 0);
        check_eq("mid_rst_overflow", overflow, 0);
        check_eq("mid_rst_init_done", init_done, 0);
        expect_cursor("mid_rst_cursor", 1'b0, 4'd0);
        rst = 1'b0;
        xfer_q.delete();

        // Stall the engine and overfill the FIFO during the restarted init.
        cmd_ready = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < int'(INIT_WAIT); i++) begin
            if (i < int'(FIFO_DEPTH) + 2) begin
                rx_data  = 8'h61 + 8'(i);
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            tick();
            any_valid |= cmd_valid;
        end
        rx_valid = 1'b0;
        check_eq("reinit_quiet", any_valid, 0);
        check_eq("ovf_fifo_count", fifo_count, FIFO_DEPTH);
        check_eq("ovf_flag", overflow, 1);
        for (int i = 0; i < 6; i++) tick();
        check_eq("stall_offer", {cmd_valid, cmd_rs, cmd_data}, {1'b1, 9'h038});

        cmd_ready = 1'b1;
        wait_xfers(4 + 2 * int'(FIFO_DEPTH));
        expect_xfer("reinit0", 9'h038);
        expect_xfer("reinit1", 9'h00C);
        expect_xfer("reinit2", 9'h006);
        expect_xfer("reinit3", 9'h001);
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            expect_xfer("drain_addr", 9'h080 + 9'(i));
            expect_xfer("drain_char", 9'h161 + 9'(i));
        end
        for (int i = 0; i < 20; i++) tick();
        check_eq("drain_extra", xfer_q.size(), 0);
        check_eq("drain_fifo", fifo_count, 0);
        check_eq("drain_overflow", overflow, 1);
        expect_cursor("drain_cursor", 1'b0, 4'(FIFO_DEPTH));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
